// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline status in, stage load/flush strobes out.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic             imem_resp;
   logic             dmem_resp;
   logic             mem_memop;
   logic             ex_is_load;
   logic [REG_W-1:0] ex_rd;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             ex_br_taken;
   logic             load_pc;
   logic             load_if_id;
   logic             load_id_ex;
   logic             load_ex_mem;
   logic             load_mem_wb;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             imem_discard;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output imem_resp, dmem_resp, mem_memop, ex_is_load, ex_rd, id_rs1, id_rs2,
             id_use_rs1, id_use_rs2, ex_br_taken,
      input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             flush_if_id, flush_id_ex, imem_discard, stall_cnt, redirect_cnt
   );

   modport slave (
      input  imem_resp, dmem_resp, mem_memop, ex_is_load, ex_rd, id_rs1, id_rs2,
             id_use_rs1, id_use_rs2, ex_br_taken,
      output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             flush_if_id, flush_id_ex, imem_discard, stall_cnt, redirect_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard controller: memory stalls, load-use bubbles, redirects and stale-fetch drain.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   hazard_ctrl_if.slave   bus
);
   typedef enum logic {RUN, DRAIN} state_t;

   state_t state_q, state_d;
   logic   dstall, lu, redirect_acc;

   assign dstall = bus.mem_memop & ~bus.dmem_resp;
   assign lu     = bus.ex_is_load & (bus.ex_rd != REG_W'(0)) &
                   ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                    (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

   always_comb begin
      bus.load_pc      = 1'b0;
      bus.load_if_id   = 1'b0;
      bus.load_id_ex   = 1'b0;
      bus.load_ex_mem  = 1'b0;
      bus.load_mem_wb  = 1'b0;
      bus.flush_if_id  = 1'b0;
      bus.flush_id_ex  = 1'b0;
      bus.imem_discard = 1'b0;
      redirect_acc     = 1'b0;
      state_d          = state_q;
      if (!rst) begin
         bus.flush_if_id = 1'b1;
         bus.flush_id_ex = 1'b1;
         state_d         = RUN;
      end else if (dstall) begin
         // Pipe frozen, but a stale fetch returning during the drain is still consumed.
         if (state_q == DRAIN && bus.imem_resp) begin
            bus.imem_discard = 1'b1;
            state_d          = RUN;
         end
      end else if (state_q == DRAIN) begin
         bus.flush_if_id = 1'b1;
         bus.load_id_ex  = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
         if (bus.imem_resp) begin
            bus.imem_discard = 1'b1;
            state_d          = RUN;
         end
      end else if (bus.ex_br_taken) begin
         bus.load_pc     = 1'b1;
         bus.flush_if_id = 1'b1;
         bus.flush_id_ex = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
         redirect_acc    = 1'b1;
         if (!bus.imem_resp) state_d = DRAIN;
      end else if (lu) begin
         bus.flush_id_ex = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
      end else if (!bus.imem_resp) begin
         bus.flush_if_id = 1'b1;
         bus.load_id_ex  = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
      end else begin
         bus.load_pc     = 1'b1;
         bus.load_if_id  = 1'b1;
         bus.load_id_ex  = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, redirect_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q    <= '0;
         redirect_q <= '0;
      end else begin
         if (!bus.load_pc) stall_q    <= stall_q + 1'b1;
         if (redirect_acc) redirect_q <= redirect_q + 1'b1;
      end
   end

   assign bus.stall_cnt    = stall_q;
   assign bus.redirect_cnt = redirect_q;
`else
   logic unused_acc;
   assign unused_acc       = redirect_acc;
   assign bus.stall_cnt    = CNT_W'(0);
   assign bus.redirect_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected strobes queued per driven cycle, compared at the negedge.
module tb_hazard_ctrl;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_W(5), .CNT_W(CW)) bus ();
   hazard_ctrl #(.REG_W(5), .CNT_W(CW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   // vec/mask bit order: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
   // flush_if_id, flush_id_ex, imem_discard; mask clears bits the behaviour leaves open.
   typedef struct packed {
      logic [7:0]    vec;
      logic [7:0]    mask;
      logic [CW-1:0] sc;
      logic [CW-1:0] rc;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   int            vectors = 0;
   int            errors  = 0;
   bit            pend    = 0;
   bit            m_drain = 0;
   logic [CW-1:0] m_sc = '0, m_rc = '0;

   function automatic logic [7:0] outs();
      return {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
              bus.flush_if_id, bus.flush_id_ex, bus.imem_discard};
   endfunction

   task automatic drive(input logic r, im, dm, mo, il, input logic [4:0] erd, r1, r2,
                        input logic u1, u2, br);
      logic       ds, lu, nd;
      logic [7:0] vec, mask;
      logic [CW-1:0] nrc;
      if (pend) begin
         @(posedge clk);
         #1;
      end
      pend = 1;
      rst = r; bus.imem_resp = im; bus.dmem_resp = dm; bus.mem_memop = mo;
      bus.ex_is_load = il; bus.ex_rd = erd; bus.id_rs1 = r1; bus.id_rs2 = r2;
      bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.ex_br_taken = br;
      if (!r) begin
         m_drain = 0; m_sc = '0; m_rc = '0;
      end
      ds  = mo & ~dm;
      lu  = il & (erd != 5'd0) & ((u1 & (r1 == erd)) | (u2 & (r2 == erd)));
      nd  = m_drain;
      nrc = m_rc;
      if (!r) begin
         vec = 8'b0000_0110; mask = 8'hFF; nd = 0;
      end else if (ds) begin
         vec = 8'h00; mask = (m_drain && im) ? 8'hFE : 8'hFF; nd = m_drain && !im;
      end else if (m_drain) begin
         vec = {7'b0011_110, im}; mask = 8'b1111_1101; nd = !im;
      end else if (br) begin
         vec = 8'b1001_1110; mask = 8'b1001_1111; nd = !im; nrc = m_rc + 1'b1;
      end else if (lu) begin
         vec = 8'b0001_1010; mask = 8'b1101_1011;
      end else if (!im) begin
         vec = 8'b0011_1100; mask = 8'b1011_1101;
      end else begin
         vec = 8'b1111_1000; mask = 8'hFF;
      end
`ifdef HAZARD_PERF_CNT_EN
      sb.push_back('{vec, mask, m_sc, m_rc});
`else
      sb.push_back('{vec, mask, CW'(0), CW'(0)});
`endif
      @(negedge clk);
      // Inputs hold until the next posedge, so the next-state can be committed now.
      if (r && !vec[7]) m_sc = m_sc + 1'b1;
      m_rc    = nrc;
      m_drain = nd;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                          5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         else       drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL reset[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1, 1, 1, 0, 1, 5, 1, 5, 0, 1, 0);
            1: drive(1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0);
            2: drive(1, 1, 1, 0, 1, 7, 7, 3, 1, 0, 0);
            default: drive(1, 1, 1, 0, 1, 7, 7, 3, 0, 1, 0);
         endcase
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL load_use[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_redirect_drain();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            1, 2: drive(1, 0, 1, 0, 1, 4, 4, 4, 1, 1, 1);
            3: drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            default: drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         endcase
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL redirect_drain[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_redirect_return();
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, (i == 0));
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL redirect_return[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_dstall_redirect();
      for (int i = 0; i < 6; i++) begin
         if (i < 4)      drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
         else if (i == 4) drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
         else            drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL dstall_redirect[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_reset_in_drain();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            1: drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            default: drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         endcase
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL reset_in_drain[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   task automatic test_counter_wrap();
      logic [CW-1:0] wrap_exp;
`ifdef HAZARD_PERF_CNT_EN
      wrap_exp = CW'(1);
`else
      wrap_exp = CW'(0);
`endif
      for (int i = 0; i < 19; i++) begin
         if (i == 0)      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i < 18) drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else             drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL counter_wrap[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
      vectors++;
      if (bus.stall_cnt !== wrap_exp) begin
         errors++;
         $display("FAIL stall_wrap got=%h exp=%h", bus.stall_cnt, wrap_exp);
      end
   endtask

   task automatic test_back_to_back();
      logic mo;
      for (int i = 0; i < 60; i++) begin
         mo = m_drain ? 1'b0 : 1'($urandom_range(0, 3) == 0);
         drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom), mo, 1'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
         e = sb.pop_front(); vectors++;
         if ((((outs() ^ e.vec) & e.mask) !== 8'h00) || bus.stall_cnt !== e.sc || bus.redirect_cnt !== e.rc) begin
            errors++;
            $display("FAIL back_to_back[%0d] got=%b/%h/%h exp=%b mask=%b/%h/%h", i, outs(), bus.stall_cnt, bus.redirect_cnt, e.vec, e.mask, e.sc, e.rc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect_drain();
      test_redirect_return();
      test_dstall_redirect();
      test_reset_in_drain();
      test_counter_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
